pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 133 +++++++++++++
 tb/tb_pwm_capture.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period capture; optional input glitch filter via PWM_CAPTURE_FILTER_EN
module pwm_capture #(
    parameter int              WIDTH      = 23,
    parameter logic [WIDTH-1:0] TIMEOUT   = 23'd5_000_000,
    parameter int              FILTER_LEN = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             PWM_in,
    output logic [WIDTH-1:0] High_cnt,
    output logic [WIDTH-1:0] Period_cnt,
    output logic             Valid,
    output logic             Timeout
);

    // Counters must be able to reach TIMEOUT without wrapping.
    if (TIMEOUT == {WIDTH{1'b1}} || FILTER_LEN < 1) begin : g_bad_params
        $error("pwm_capture: TIMEOUT must be below 2^WIDTH-1 and FILTER_LEN at least 1");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic             s;
    logic             s_d;
    logic [WIDTH-1:0] high_ctr;
    logic [WIDTH-1:0] period_ctr;
    logic             rise;
    logic             fall;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= PWM_in;
            sync2 <= sync1;
            s_d   <= s;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0] filt_cnt;

    // s follows sync2 only once the new level has held for FILTER_LEN clocks.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s        <= 1'b0;
            filt_cnt <= '0;
        end else if (sync2 == s) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            s        <= sync2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
`else
    assign s = sync2;
`endif

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            high_ctr   <= '0;
            period_ctr <= '0;
            High_cnt   <= '0;
            Period_cnt <= '0;
            Valid      <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: begin
                    high_ctr   <= '0;
                    period_ctr <= '0;
                    if (rise) begin
                        state      <= HIGH;
                        high_ctr   <= {{(WIDTH-1){1'b0}}, 1'b1};
                        period_ctr <= {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state      <= LOW;
                        period_ctr <= period_ctr + 1'b1;
                    end else if (period_ctr >= TIMEOUT) begin
                        state      <= IDLE;
                        high_ctr   <= '0;
                        period_ctr <= '0;
                        Timeout    <= 1'b1;
                    end else begin
                        high_ctr   <= high_ctr + 1'b1;
                        period_ctr <= period_ctr + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state      <= HIGH;
                        High_cnt   <= high_ctr;
                        Period_cnt <= period_ctr;
                        Valid      <= 1'b1;
                        Timeout    <= 1'b0;
                        high_ctr   <= {{(WIDTH-1){1'b0}}, 1'b1};
                        period_ctr <= {{(WIDTH-1){1'b0}}, 1'b1};
                    end else if (period_ctr >= TIMEOUT) begin
                        state      <= IDLE;
                        high_ctr   <= '0;
                        period_ctr <= '0;
                        Timeout    <= 1'b1;
                    end else begin
                        period_ctr <= period_ctr + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    high_ctr   <= '0;
                    period_ctr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture (TIMEOUT shortened to 1000)
module tb_pwm_capture;

    localparam int W    = 23;
    localparam int TO_P = 1000;
    localparam int FLEN = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int DUTY_MIN = 5;
    localparam int DUTY_MAX = 35;
    localparam int GL_DELTA = 3;
    localparam int GL_H     = 25;
    localparam int GL_P     = 100;
`else
    localparam int DUTY_MIN = 1;
    localparam int DUTY_MAX = 39;
    localparam int GL_DELTA = 5;
    localparam int GL_H     = 13;
    localparam int GL_P     = 88;
`endif

    logic         CLK;
    logic         RSTn;
    logic         PWM_in;
    logic [W-1:0] High_cnt;
    logic [W-1:0] Period_cnt;
    logic         Valid;
    logic         Timeout;

    pwm_capture #(.WIDTH(W), .TIMEOUT(23'd1000), .FILTER_LEN(FLEN)) dut (
        .CLK(CLK), .RSTn(RSTn), .PWM_in(PWM_in),
        .High_cnt(High_cnt), .Period_cnt(Period_cnt),
        .Valid(Valid), .Timeout(Timeout)
    );

    typedef struct {int h; int p;} exp_t;
    exp_t exp_q[$];

    int  tests_run = 0;
    int  failures  = 0;
    int  cyc = 0;
    int  valid_seen = 0;
    int  last_valid_cyc = 0;
    bit  prev_valid = 0;

    bit  m_prev = 0, m_armed = 0, m_inhigh = 0, m_flev = 0;
    int  m_h = 0, m_p = 0, m_frun = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural pin-level model: one call per driven clock.
    task automatic model_step(input bit pin);
        bit lv;
`ifdef PWM_CAPTURE_FILTER_EN
        if (pin != m_flev) begin
            m_frun++;
            if (m_frun >= FLEN) begin
                m_flev = pin;
                m_frun = 0;
            end
        end else begin
            m_frun = 0;
        end
        lv = m_flev;
`else
        lv = pin;
`endif
        if (lv && !m_prev) begin
            if (m_armed) exp_q.push_back('{m_h, m_p});
            m_armed = 1; m_h = 0; m_p = 0; m_inhigh = 1;
        end else if (m_armed && m_p >= TO_P) begin
            m_armed = 0;
        end
        if (m_armed) begin
            m_p++;
            if (lv && m_inhigh) m_h++;
        end
        if (!lv) m_inhigh = 0;
        m_prev = lv;
    endtask

    task automatic model_reset();
        m_prev = 0; m_armed = 0; m_inhigh = 0; m_flev = 0;
        m_h = 0; m_p = 0; m_frun = 0;
    endtask

    task automatic drive_bit(input bit b);
        @(negedge CLK);
        PWM_in = b;
        model_step(b);
    endtask

    task automatic pwm_cycle(input int h, input int p);
        for (int i = 0; i < p; i++) drive_bit(i < h);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) drive_bit(1'b0);
    endtask

    task automatic close_cycle();
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        drain();
    endtask

    always @(negedge CLK) begin
        if (RSTn === 1'b1 && Valid === 1'b1) begin
            valid_seen++;
            last_valid_cyc = cyc;
            tests_run++;
            if (prev_valid) begin
                failures++;
                $display("FAIL valid_width: Valid high on consecutive cycles, required single-cycle strobe");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got High_cnt=%0d Period_cnt=%0d, required no Valid", High_cnt, Period_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (High_cnt !== W'(e.h) || Period_cnt !== W'(e.p) || Timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL measurement: got %0d/%0d timeout=%b, required %0d/%0d timeout=0",
                             High_cnt, Period_cnt, Timeout, e.h, e.p);
                end
            end
        end
        prev_valid = (RSTn === 1'b1) && (Valid === 1'b1);
    end

    task automatic test_reset();
        RSTn = 1'b0;
        PWM_in = 1'b0;
        repeat (4) @(negedge CLK);
        tests_run++;
        if (High_cnt !== '0 || Period_cnt !== '0) begin
            failures++;
            $display("FAIL reset_counts: got %0d/%0d, required 0/0", High_cnt, Period_cnt);
        end
        tests_run++;
        if (Valid !== 1'b0 || Timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got valid=%b timeout=%b, required 0/0", Valid, Timeout);
        end
        RSTn = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int v0 = valid_seen;
        for (int c = 0; c < 3; c++) pwm_cycle(25, 100);
        drain();
        tests_run++;
        if (valid_seen - v0 !== 2) begin
            failures++;
            $display("FAIL basic_valid_count: got %0d, required 2", valid_seen - v0);
        end
        tests_run++;
        if (High_cnt !== 23'd25 || Period_cnt !== 23'd100 || Timeout !== 1'b0) begin
            failures++;
            $display("FAIL basic_values: got %0d/%0d timeout=%b, required 25/100 timeout=0", High_cnt, Period_cnt, Timeout);
        end
    endtask

    task automatic test_duty_change();
        int v0 = valid_seen;
        pwm_cycle(DUTY_MAX, 40);
        pwm_cycle(DUTY_MAX, 40);
        tests_run++;
        if (High_cnt !== W'(DUTY_MAX) || Period_cnt !== 23'd40) begin
            failures++;
            $display("FAIL duty_max: got %0d/%0d, required %0d/40", High_cnt, Period_cnt, DUTY_MAX);
        end
        pwm_cycle(DUTY_MIN, 40);
        pwm_cycle(DUTY_MIN, 40);
        close_cycle();
        tests_run++;
        if (High_cnt !== W'(DUTY_MIN) || Period_cnt !== 23'd40) begin
            failures++;
            $display("FAIL duty_min: got %0d/%0d, required %0d/40", High_cnt, Period_cnt, DUTY_MIN);
        end
        tests_run++;
        if (valid_seen - v0 !== 5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL duty_valid_count: got %0d pending=%0d, required 5 pending=0", valid_seen - v0, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int v0;
        int t_cyc = -1;
        for (int i = 0; i < 1100; i++) drive_bit(1'b0);
        tests_run++;
        if (Timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_idle: got %b, required 1", Timeout);
        end
        v0 = valid_seen;
        pwm_cycle(25, 100);
        close_cycle();
        for (int i = 0; i < 1200; i++) begin
            drive_bit(1'b0);
            if (t_cyc < 0 && Timeout === 1'b1) t_cyc = cyc;
        end
        tests_run++;
        if (valid_seen - v0 !== 1) begin
            failures++;
            $display("FAIL timeout_valid_count: got %0d, required 1", valid_seen - v0);
        end
        tests_run++;
        if (t_cyc - last_valid_cyc !== TO_P) begin
            failures++;
            $display("FAIL timeout_delay: got %0d clocks, required %0d", t_cyc - last_valid_cyc, TO_P);
        end
        tests_run++;
        if (High_cnt !== 23'd25 || Period_cnt !== 23'd100 || Timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_hold: got %0d/%0d timeout=%b, required 25/100 timeout=1", High_cnt, Period_cnt, Timeout);
        end
    endtask

    task automatic test_resume();
        int v0 = valid_seen;
        pwm_cycle(25, 100);
        tests_run++;
        if (valid_seen - v0 !== 0 || Timeout !== 1'b1) begin
            failures++;
            $display("FAIL resume_first_edge: got %0d valids timeout=%b, required 0 valids timeout=1", valid_seen - v0, Timeout);
        end
        close_cycle();
        tests_run++;
        if (valid_seen - v0 !== 1 || High_cnt !== 23'd25 || Period_cnt !== 23'd100 || Timeout !== 1'b0) begin
            failures++;
            $display("FAIL resume_second_edge: got %0d valids %0d/%0d timeout=%b, required 1 valid 25/100 timeout=0",
                     valid_seen - v0, High_cnt, Period_cnt, Timeout);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        for (int i = 0; i < 51; i++) drive_bit(1'b1);
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pre_reset_pending: got %0d queued, required 0", exp_q.size());
        end
        @(negedge CLK);
        RSTn = 1'b0;
        PWM_in = 1'b0;
        #1;
        tests_run++;
        if (High_cnt !== '0 || Period_cnt !== '0 || Valid !== 1'b0 || Timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got %0d/%0d valid=%b timeout=%b, required all 0", High_cnt, Period_cnt, Valid, Timeout);
        end
        model_reset();
        repeat (5) @(negedge CLK);
        RSTn = 1'b1;
        v0 = valid_seen;
        pwm_cycle(25, 100);
        tests_run++;
        if (valid_seen - v0 !== 0) begin
            failures++;
            $display("FAIL reset_first_edge: got %0d valids, required 0", valid_seen - v0);
        end
        close_cycle();
        tests_run++;
        if (valid_seen - v0 !== 1 || High_cnt !== 23'd25 || Period_cnt !== 23'd100) begin
            failures++;
            $display("FAIL reset_second_edge: got %0d valids %0d/%0d, required 1 valid 25/100", valid_seen - v0, High_cnt, Period_cnt);
        end
    endtask

    task automatic test_glitch();
        int v0 = valid_seen;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 100; i++) drive_bit((i < 25) && (i != 10) && (i != 11));
        close_cycle();
        tests_run++;
        if (valid_seen - v0 !== GL_DELTA) begin
            failures++;
            $display("FAIL glitch_valid_count: got %0d, required %0d", valid_seen - v0, GL_DELTA);
        end
        tests_run++;
        if (High_cnt !== W'(GL_H) || Period_cnt !== W'(GL_P)) begin
            failures++;
            $display("FAIL glitch_values: got %0d/%0d, required %0d/%0d", High_cnt, Period_cnt, GL_H, GL_P);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_pending: got %0d queued, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_timeout();
        test_resume();
        test_reset_mid();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish before 1 ms");
        $fatal(1, "watchdog");
    end

endmodule
